// File: rtl/bbqm_pkg.sv
// Shared constants for the bank queue manager: people-count width, saturation ceiling
// and debounce length. The waiting-time lookup stage imports the same package.
package bbqm_pkg;

  localparam int DEF_PCOUNT_W   = 3;
  localparam int DEF_MAX_COUNT  = 7;
  localparam int DEF_DEB_CYCLES = 4;

  typedef logic [DEF_PCOUNT_W-1:0] count_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sensor_conditioner.sv
// Photocell front-end: two-flop synchroniser, consecutive-sample debounce filter and a
// one-cycle registered pulse on every accepted 0->1 transition of the filtered level.
module sensor_conditioner import bbqm_pkg::*; #(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int            CW   = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d, filt_dly_q;
  logic          pulse_q;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;

  // The DEB_CYCLES-th consecutive mismatching sample flips the filter and clears the counter.
  always_comb begin
    deb_cnt_d = '0;
    filt_d    = filt_q;
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == LAST) begin
        filt_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      pulse_q    <= filt_q & ~filt_dly_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/queue_people_counter.sv
// Queue occupancy front-end: conditions entry/exit photocells and keeps a saturating count.
// Defining QCOUNT_ALARM_EN adds a sticky over/underflow alarm (ovf_alarm, alarm_clr).
module queue_people_counter import bbqm_pkg::*; #(
  parameter int PCOUNT_W   = DEF_PCOUNT_W,
  parameter int MAX_COUNT  = DEF_MAX_COUNT,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sens_in,
  input  logic                sens_out,
  output logic [PCOUNT_W-1:0] pcount,
  output logic                full,
  output logic                empty
`ifdef QCOUNT_ALARM_EN
  ,
  input  logic                alarm_clr,
  output logic                ovf_alarm
`endif
);

  localparam logic [PCOUNT_W-1:0] MAX_C = PCOUNT_W'(MAX_COUNT);

  logic                in_pulse, out_pulse;
  logic                inc, dec;
  logic [PCOUNT_W-1:0] pcount_q, pcount_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  sensor_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_in (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (sens_in),
    .pulse_o (in_pulse)
  );

  sensor_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_out (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (sens_out),
    .pulse_o (out_pulse)
  );

  // Coinciding entry and exit pulses cancel out.
  assign inc = in_pulse & ~out_pulse;
  assign dec = out_pulse & ~in_pulse;

  // Flags derive from the next count so they register in the same edge as pcount.
  always_comb begin
    pcount_d = pcount_q;
    if (inc && (pcount_q != MAX_C)) begin
      pcount_d = pcount_q + PCOUNT_W'(1);
    end else if (dec && (pcount_q != '0)) begin
      pcount_d = pcount_q - PCOUNT_W'(1);
    end
    full_d  = (pcount_d == MAX_C);
    empty_d = (pcount_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcount_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      pcount_q <= pcount_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign pcount = pcount_q;
  assign full   = full_q;
  assign empty  = empty_q;

`ifdef QCOUNT_ALARM_EN
  logic alarm_q, alarm_d, alarm_set;

  // A new over/underflow in the clearing cycle keeps the alarm raised.
  assign alarm_set = (inc & full_q) | (dec & empty_q);

  always_comb begin
    alarm_d = alarm_q;
    if (alarm_set) begin
      alarm_d = 1'b1;
    end else if (alarm_clr) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign ovf_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_queue_people_counter.sv
// Self-checking bench for queue_people_counter: directed scenarios with expected values
// from the counting rules, plus a randomized run against an event-level reference model.
`timescale 1ns/1ps
module tb_queue_people_counter;
  import bbqm_pkg::*;

  localparam int W    = DEF_PCOUNT_W;
  localparam int MAXC = DEF_MAX_COUNT;
  localparam int DEB  = DEF_DEB_CYCLES;
  localparam int LAT  = DEB + 4;
  localparam int NRND = 600;
  localparam int NT   = NRND + 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sens_in = 1'b0;
  logic         sens_out = 1'b0;
  logic [W-1:0] pcount;
  logic         full, empty;
`ifdef QCOUNT_ALARM_EN
  logic         alarm_clr = 1'b0;
  logic         ovf_alarm;
  bit           alm_q[$];
`endif

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic         rin  [0:NT];
  logic         rout [0:NT];
  logic         clr  [0:NT];

  queue_people_counter dut (
    .clk      (clk),
    .rst      (rst),
    .sens_in  (sens_in),
    .sens_out (sens_out),
    .pcount   (pcount),
    .full     (full),
    .empty    (empty)
`ifdef QCOUNT_ALARM_EN
    ,
    .alarm_clr(alarm_clr),
    .ovf_alarm(ovf_alarm)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change on the falling edge, outputs are sampled 1ns after the rising edge.
  task automatic tick(input logic i, input logic o);
    @(negedge clk);
    sens_in  = i;
    sens_out = o;
    @(posedge clk);
    #1;
  endtask

  // One clean event: high long enough to be accepted, then low long enough to settle fully.
  task automatic event_pulse(input logic i, input logic o);
    repeat (DEB + 2) tick(i, o);
    repeat (DEB + 4) tick(1'b0, 1'b0);
  endtask

`ifdef QCOUNT_ALARM_EN
  task automatic pulse_clear();
    @(negedge clk);
    alarm_clr = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    alarm_clr = 1'b0;
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    checks++;
    if (pcount !== W'(0)) begin failures++; $display("FAIL reset_pcount: got %0d expected 0", pcount); end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++;
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
`ifdef QCOUNT_ALARM_EN
    checks++;
    if (ovf_alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm: got %b expected 0", ovf_alarm); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_first_entry();
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (pcount !== W'(k >= LAT)) begin
        failures++; $display("FAIL first_entry_pcount edge %0d: got %0d expected %0d", k, pcount, (k >= LAT));
      end
      checks++;
      if (empty !== (k < LAT)) begin
        failures++; $display("FAIL first_entry_empty edge %0d: got %b expected %b", k, empty, (k < LAT));
      end
    end
    repeat (DEB + 4) tick(1'b0, 1'b0);
    checks++;
    if (pcount !== W'(1)) begin failures++; $display("FAIL first_entry_hold: got %0d expected 1", pcount); end
  endtask

  task automatic test_saturate();
    int exp_c;
    for (int i = 2; i <= MAXC + 1; i++) begin
      event_pulse(1'b1, 1'b0);
      exp_c = (i > MAXC) ? MAXC : i;
      checks++;
      if (pcount !== W'(exp_c)) begin failures++; $display("FAIL saturate_pcount %0d: got %0d expected %0d", i, pcount, exp_c); end
      checks++;
      if (full !== (exp_c == MAXC)) begin failures++; $display("FAIL saturate_full %0d: got %b expected %b", i, full, (exp_c == MAXC)); end
`ifdef QCOUNT_ALARM_EN
      checks++;
      if (ovf_alarm !== (i > MAXC)) begin failures++; $display("FAIL saturate_alarm %0d: got %b expected %b", i, ovf_alarm, (i > MAXC)); end
`endif
    end
`ifdef QCOUNT_ALARM_EN
    repeat (5) tick(1'b0, 1'b0);
    checks++;
    if (ovf_alarm !== 1'b1) begin failures++; $display("FAIL alarm_sticky: got %b expected 1", ovf_alarm); end
    pulse_clear();
    checks++;
    if (ovf_alarm !== 1'b0) begin failures++; $display("FAIL alarm_clear: got %b expected 0", ovf_alarm); end
`endif
  endtask

  task automatic test_drain();
    int exp_c;
    for (int i = 1; i <= MAXC + 1; i++) begin
      event_pulse(1'b0, 1'b1);
      exp_c = (i > MAXC) ? 0 : MAXC - i;
      checks++;
      if (pcount !== W'(exp_c)) begin failures++; $display("FAIL drain_pcount %0d: got %0d expected %0d", i, pcount, exp_c); end
      checks++;
      if (empty !== (exp_c == 0)) begin failures++; $display("FAIL drain_empty %0d: got %b expected %b", i, empty, (exp_c == 0)); end
`ifdef QCOUNT_ALARM_EN
      checks++;
      if (ovf_alarm !== (i > MAXC)) begin failures++; $display("FAIL underflow_alarm %0d: got %b expected %b", i, ovf_alarm, (i > MAXC)); end
`endif
    end
`ifdef QCOUNT_ALARM_EN
    pulse_clear();
`endif
  endtask

  task automatic test_glitch();
    repeat (DEB - 1) tick(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (pcount !== W'(0)) begin failures++; $display("FAIL glitch_pcount %0d: got %0d expected 0", k, pcount); end
    end
    // Exactly DEB cycles high is the shortest accepted level.
    repeat (DEB) tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    checks++;
    if (pcount !== W'(1)) begin failures++; $display("FAIL min_width_pcount: got %0d expected 1", pcount); end
    event_pulse(1'b0, 1'b1);
    checks++;
    if (pcount !== W'(0)) begin failures++; $display("FAIL glitch_restore: got %0d expected 0", pcount); end
  endtask

  task automatic test_chatter();
    for (int k = 0; k < 20; k++) begin
      tick(logic'(k % 2 == 0), 1'b0);
      checks++;
      if (pcount !== W'(0)) begin failures++; $display("FAIL chatter_pcount %0d: got %0d expected 0", k, pcount); end
    end
    repeat (DEB + 4) tick(1'b1, 1'b0);
    repeat (DEB + 4) tick(1'b0, 1'b0);
    checks++;
    if (pcount !== W'(1)) begin failures++; $display("FAIL chatter_settle: got %0d expected 1", pcount); end
    event_pulse(1'b0, 1'b1);
  endtask

  task automatic test_coincident();
    int exp_c;
    exp_c = 0;
    for (int step = 0; step < 3; step++) begin
      event_pulse(1'b1, 1'b1);
      checks++;
      if (pcount !== W'(exp_c)) begin failures++; $display("FAIL both_pcount at %0d: got %0d expected %0d", exp_c, pcount, exp_c); end
      checks++;
      if (full !== (exp_c == MAXC) || empty !== (exp_c == 0)) begin
        failures++; $display("FAIL both_flags at %0d: got full=%b empty=%b", exp_c, full, empty);
      end
`ifdef QCOUNT_ALARM_EN
      checks++;
      if (ovf_alarm !== 1'b0) begin failures++; $display("FAIL both_alarm at %0d: got %b expected 0", exp_c, ovf_alarm); end
`endif
      if (step < 2) begin
        repeat ((step == 0) ? 3 : MAXC - 3) event_pulse(1'b1, 1'b0);
        exp_c = (step == 0) ? 3 : MAXC;
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    repeat (3) tick(1'b1, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (pcount !== W'(0) || empty !== 1'b1 || full !== 1'b0) begin
        failures++; $display("FAIL mid_reset_state %0d: got pcount=%0d empty=%b full=%b expected 0/1/0", k, pcount, empty, full);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (pcount !== W'(k >= LAT)) begin
        failures++; $display("FAIL post_reset_pcount edge %0d: got %0d expected %0d", k, pcount, (k >= LAT));
      end
    end
    repeat (DEB + 4) tick(1'b0, 1'b0);
    checks++;
    if (pcount !== W'(1)) begin failures++; $display("FAIL post_reset_once: got %0d expected 1", pcount); end
  endtask

  // Reference model: every clean raw rise sampled at edge s moves the count at edge s+DEB+3.
  task automatic test_random();
    int           cnt;
    bit           ein, eout, alm, set;
    logic [W-1:0] exp_c;
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k <= NT; k++) begin
      rin[k] = 1'b0; rout[k] = 1'b0;
      clr[k] = logic'($urandom_range(0, 15) == 0);
    end
    for (int s = 0; s < 2; s++) begin
      int   idx;
      logic lvl;
      idx = 1;
      lvl = 1'b0;
      while (idx <= NRND) begin
        int len;
        len = lvl ? int'($urandom_range(DEB, DEB + 5)) : int'($urandom_range(DEB, DEB + 8));
        for (int j = 0; j < len; j++) begin
          if (s == 0) rin[idx] = lvl; else rout[idx] = lvl;
          idx++;
        end
        lvl = ~lvl;
      end
    end
    cnt = 0;
    alm = 1'b0;
    for (int k = 1; k <= NT; k++) begin
      ein = 1'b0; eout = 1'b0;
      if (k - DEB - 3 >= 1) begin
        ein  = rin[k-DEB-3]  && !rin[k-DEB-4];
        eout = rout[k-DEB-3] && !rout[k-DEB-4];
      end
      set = (ein && !eout && cnt == MAXC) || (eout && !ein && cnt == 0);
      alm = set ? 1'b1 : (clr[k] ? 1'b0 : alm);
      if (ein && !eout && cnt < MAXC) cnt = cnt + 1;
      else if (eout && !ein && cnt > 0) cnt = cnt - 1;
      exp_q.push_back(W'(cnt));
`ifdef QCOUNT_ALARM_EN
      alm_q.push_back(alm);
`endif
    end
    for (int k = 1; k <= NT; k++) begin
      @(negedge clk);
      sens_in  = rin[k];
      sens_out = rout[k];
`ifdef QCOUNT_ALARM_EN
      alarm_clr = clr[k];
`endif
      @(posedge clk);
      #1;
      exp_c = exp_q.pop_front();
      checks++;
      if (pcount !== exp_c) begin failures++; $display("FAIL rand_pcount edge %0d: got %0d expected %0d", k, pcount, exp_c); end
      checks++;
      if (full !== (exp_c == W'(MAXC)) || empty !== (exp_c == W'(0))) begin
        failures++; $display("FAIL rand_flags edge %0d: got full=%b empty=%b for count %0d", k, full, empty, exp_c);
      end
`ifdef QCOUNT_ALARM_EN
      begin
        bit ea;
        ea = alm_q.pop_front();
        checks++;
        if (ovf_alarm !== ea) begin failures++; $display("FAIL rand_alarm edge %0d: got %b expected %b", k, ovf_alarm, ea); end
      end
`endif
    end
`ifdef QCOUNT_ALARM_EN
    @(negedge clk);
    alarm_clr = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_first_entry();
    test_saturate();
    test_drain();
    test_glitch();
    test_chatter();
    test_coincident();
    test_reset_mid_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
